// File: rtl/kmeans_pkg.sv
// ---------------------------------------------------------------------------
// kmeans_pkg
// Shared constants and types for the k-means engine.
//   KM_ADDR_W / KM_DATA_W / KM_DATA_SIZE : point SRAM geometry (4096 x 16)
//   KM_SRAM_RD_LAT                       : grant-to-data read latency
//   KM_FLIGHT_W                          : width of an in-flight read count
//   km_point_t                           : one SRAM word, {x[7:0], y[7:0]}
//   km_gnt_e                             : which requester was granted last
//   km_popcount()                        : counts set bits of a pipeline
// ---------------------------------------------------------------------------
package kmeans_pkg;

    localparam int KM_ADDR_W      = 12;
    localparam int KM_DATA_W      = 16;
    localparam int KM_DATA_SIZE   = 4096;
    localparam int KM_SRAM_RD_LAT = 3;
    localparam int KM_FLIGHT_W    = $clog2(KM_SRAM_RD_LAT + 1);

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } km_point_t;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } km_gnt_e;

    function automatic logic [KM_FLIGHT_W-1:0] km_popcount(
        input logic [KM_SRAM_RD_LAT-1:0] v
    );
        logic [KM_FLIGHT_W-1:0] n;
        n = '0;
        for (int i = 0; i < KM_SRAM_RD_LAT; i++) begin
            n = n + KM_FLIGHT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/kmeans_sram_arb_if.sv
// ---------------------------------------------------------------------------
// kmeans_sram_arb_if
// Bundles the loader write port, grouping-engine read port, drain handshake
// and SRAM pins of the point-SRAM arbiter.
//   modport slave  : the arbiter side (kmeans_sram_arb)
//   modport master : requesters plus the SRAM macro driving mem_dout
// ---------------------------------------------------------------------------
interface kmeans_sram_arb_if
    import kmeans_pkg::*;
#(
    parameter int ADDR_W = KM_ADDR_W,
    parameter int DATA_W = KM_DATA_W
);

    // write port (data loader)
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;

    // read port (grouping engine)
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    // phase-change handshake
    logic              drain_req;
    logic              drain_ack;

    // SRAM pins
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_we_b;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, drain_req, mem_dout,
        output wr_gnt, rd_gnt, rd_valid, rd_data, drain_ack,
               mem_addr, mem_din, mem_we_b
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, drain_req, mem_dout,
        input  wr_gnt, rd_gnt, rd_valid, rd_data, drain_ack,
               mem_addr, mem_din, mem_we_b
    );

endinterface

// File: rtl/kmeans_rd_pipe.sv
// ---------------------------------------------------------------------------
// kmeans_rd_pipe
// Tracks granted reads through the SRAM and captures the returned word.
// A KM_SRAM_RD_LAT-deep valid shift register follows each read; the word is
// captured from mem_dout as its valid bit enters the last stage.
//   clk, rst_n : clock, synchronous active-low reset (drops in-flight reads)
//   issue      : a read was granted this cycle
//   mem_dout   : SRAM read data
//   rd_valid   : rd_data holds a returned word (one pulse per read)
//   rd_data    : registered read data
//   in_flight  : number of reads granted but not yet returned (incl. this one)
// ---------------------------------------------------------------------------
module kmeans_rd_pipe
    import kmeans_pkg::*;
#(
    parameter int DATA_W = KM_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue,
    input  logic [DATA_W-1:0]      mem_dout,
    output logic                   rd_valid,
    output logic [DATA_W-1:0]      rd_data,
    output logic [KM_FLIGHT_W-1:0] in_flight
);

    // stage_q[0] = address being registered, stage_q[LAT-1] = data presented
    logic [KM_SRAM_RD_LAT-1:0] stage_q;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q <= '0;
            rd_data <= '0;
        end else begin
            stage_q <= {stage_q[KM_SRAM_RD_LAT-2:0], issue};
            if (stage_q[KM_SRAM_RD_LAT-2]) begin
                rd_data <= mem_dout;
            end
        end
    end

    assign rd_valid  = stage_q[KM_SRAM_RD_LAT-1];
    assign in_flight = km_popcount(stage_q);

endmodule

// File: rtl/kmeans_sram_arb.sv
// ---------------------------------------------------------------------------
// kmeans_sram_arb
// Shares the single-port point SRAM between the data loader (writes) and the
// grouping engine (reads). At most one access is granted per cycle and the
// SRAM address, data and active-low write enable are driven from registers.
// Reads return in grant order KM_SRAM_RD_LAT cycles after their grant.
// drain_req blocks new grants; drain_ack reports that no read is in flight.
//
// Build option:
//   KMEANS_ARB_RR_EN defined   : round-robin between the two requesters
//   KMEANS_ARB_RR_EN undefined : write always wins over read
//
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : kmeans_sram_arb_if.slave (request/grant ports, read return,
//           drain handshake, SRAM pins)
// ---------------------------------------------------------------------------
module kmeans_sram_arb
    import kmeans_pkg::*;
#(
    parameter int ADDR_W = KM_ADDR_W,
    parameter int DATA_W = KM_DATA_W
) (
    input logic              clk,
    input logic              rst_n,
    kmeans_sram_arb_if.slave bus
);

    logic                   wr_gnt;
    logic                   rd_gnt;
    km_gnt_e                last_gnt_q;
    km_gnt_e                last_gnt_d;
    logic [ADDR_W-1:0]      mem_addr_q;
    logic [DATA_W-1:0]      mem_din_q;
    logic                   mem_we_b_q;
    logic [KM_FLIGHT_W-1:0] in_flight;

    // -----------------------------------------------------------------------
    // Grant selection. Requests are ignored while in reset or draining.
    // -----------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else can leave it unassigned and infer a latch.
    always_comb begin
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        if (rst_n && !bus.drain_req) begin
            if (bus.wr_req && bus.rd_req) begin
`ifdef KMEANS_ARB_RR_EN
                // whoever did not win last time wins now
                if (last_gnt_q == GNT_RD) begin
                    wr_gnt = 1'b1;
                end else begin
                    rd_gnt = 1'b1;
                end
`else
                wr_gnt = 1'b1;
`endif
            end else begin
                wr_gnt = bus.wr_req;
                rd_gnt = bus.rd_req;
            end
        end
    end

    // last_gnt only moves when something is granted
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (wr_gnt) begin
            last_gnt_d = GNT_WR;
        end else if (rd_gnt) begin
            last_gnt_d = GNT_RD;
        end
    end

    // Reset value GNT_RD makes the first contended grant go to the write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt_q <= GNT_RD;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // SRAM command registers. The address holds when idle; data is zeroed
    // whenever no write is issued so stale write data never sits on DI.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_we_b_q <= 1'b1;
        end else begin
            mem_we_b_q <= ~wr_gnt;
            mem_din_q  <= wr_gnt ? bus.wr_data : '0;
            if (wr_gnt) begin
                mem_addr_q <= bus.wr_addr;
            end else if (rd_gnt) begin
                mem_addr_q <= bus.rd_addr;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read return pipeline
    // -----------------------------------------------------------------------
    kmeans_rd_pipe #(
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (rd_gnt),
        .mem_dout  (bus.mem_dout),
        .rd_valid  (bus.rd_valid),
        .rd_data   (bus.rd_data),
        .in_flight (in_flight)
    );

    assign bus.wr_gnt    = wr_gnt;
    assign bus.rd_gnt    = rd_gnt;
    assign bus.drain_ack = rst_n & bus.drain_req & (in_flight == '0);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_din   = mem_din_q;
    assign bus.mem_we_b  = mem_we_b_q;

endmodule

// File: doc/kmeans_sram_arb.md
# kmeans_sram_arb

Two-requester arbiter and sequencer for the single 4096x16 single-port SRAM in the k-means engine. It shares the SRAM between the data loader (write port, filling points during input) and the grouping engine (read port, streaming points every pass). It grants at most one access per cycle and drives the registered SRAM address, data and active-low write-enable. It returns read data with fixed latency and supports a drain handshake so the top FSM can change phase only with no reads in flight.

## Interface
- ADDR_W, 12, SRAM address width (4096 words)
- DATA_W, 16, SRAM word width ({x[7:0], y[7:0]})
- clk  input  1  sole clock, rising edge
- rst_n  input  1  synchronous, active-low reset
- wr_req  input  1  loader write request; held with wr_addr/wr_data stable until granted
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- wr_gnt  output  1  write accepted this cycle (combinational)
- rd_req  input  1  grouping-engine read request; held with rd_addr stable until granted
- rd_addr  input  ADDR_W  read address
- rd_gnt  output  1  read accepted this cycle (combinational)
- rd_valid  output  1  rd_data valid, one pulse per granted read
- rd_data  output  DATA_W  registered read data
- drain_req  input  1  block new grants; level
- drain_ack  output  1  drain_req high and zero reads in flight
- mem_addr  output  ADDR_W  SRAM A, registered
- mem_din  output  DATA_W  SRAM DI, registered
- mem_we_b  output  1  SRAM WEB, registered, 0 = write
- mem_dout  input  DATA_W  SRAM DO

## Operation
- Grant logic is combinational from the requests, drain_req and the last_gnt flop (0 = write, 1 = read).
- At most one of wr_gnt and rd_gnt is high in any cycle. Neither is high while drain_req = 1.
- Only one request: that request is granted.
- Both requests:
  - Round-robin build: the requester not granted last wins.
  - Fixed build: write wins.
- last_gnt updates only on a grant.
- Issue on write grant: next edge loads mem_addr <= wr_addr, mem_din <= wr_data, mem_we_b <= 0.
- Issue on read grant: next edge loads mem_addr <= rd_addr, mem_we_b <= 1, mem_din <= 0.
- No grant: next edge sets mem_we_b <= 1 and mem_din <= 0. mem_addr holds.
- Read return: a 3-stage valid shift register tracks granted reads. Stage 3 loads rd_data <= mem_dout and pulses rd_valid.
- In-flight counter: 0..3, computed as the popcount of the pipeline stages. Overflow is impossible because only one grant is made per cycle.
- Reads return in grant order. A write issued after a read to the same address never corrupts that read; the SRAM serialises accesses.
- drain_ack = drain_req & (in_flight == 0). While drain_req = 1, any held request stays pending with its gnt low.
- Reset values:
  - wr_gnt = rd_gnt = 0 (requests are ignored during reset)
  - rd_valid = 0, rd_data = 0
  - mem_addr = 0, mem_din = 0, mem_we_b = 1
  - last_gnt = 1 (so the first contended grant goes to write in both builds)
  - pipeline cleared, drain_ack = 0
- Reset mid-operation discards in-flight reads: no rd_valid appears after reset release for reads granted before reset.

## Timing
- Grant in cycle T.
- mem_* updated at the end of T.
- SRAM samples at the end of T+1; mem_dout is valid in T+2.
- rd_valid/rd_data are high in T+3. Read latency is 3 cycles grant-to-data.
- Throughput: one access per cycle, so back-to-back reads give rd_valid on consecutive cycles.
- Fixed build: a continuous wr_req starves reads. Round-robin build: each requester waits at most one cycle under contention.
- drain_ack rises at most 3 cycles after drain_req. It falls in the same cycle drain_req falls.

## Configuration
- KMEANS_ARB_RR_EN defined: round-robin on contention, as above.
- Undefined: fixed write-over-read priority. last_gnt is still maintained but does not affect the choice.
- Latency, drain behaviour and reset behaviour are identical in both builds.

## Structure
- Shared package kmeans_pkg:
  - KM_ADDR_W = 12, KM_DATA_W = 16, KM_DATA_SIZE = 4096
  - KM_SRAM_RD_LAT = 3
  - typedef for the point word (x/y byte fields)
  - enum for last_gnt (GNT_WR, GNT_RD)
- Sub-module kmeans_rd_pipe: depth-KM_SRAM_RD_LAT valid shift register plus the output data register. It exposes in_flight and rd_valid/rd_data.
- SRAM macro is instantiated at the top, not inside this block.

## Test plan
- Reset with both requests high → no grants, mem_we_b = 1, mem_addr = 0, rd_valid = 0 until the first cycle after rst_n = 1.
- Write 0xA55A to 0x123, then read 0x123 → mem_we_b = 0 for one cycle with mem_din = 0xA55A; rd_valid exactly 3 cycles after rd_gnt with rd_data = 0xA55A.
- Reads to addresses 0..7 back-to-back (preloaded addr k holds k) → 8 consecutive rd_valid pulses, data 0..7 in order, first one 3 cycles after the first grant.
- Both requesters held high for 6 cycles:
  - RR build: grants alternate W,R,W,R,W,R.
  - Fixed build: 6 write grants, 0 read grants.
- Two reads granted, then drain_req = 1 with rd_req still high → no further grants; drain_ack rises on the cycle after the second rd_valid. Releasing drain_req lets rd_gnt resume in that cycle.
- rst_n pulsed low one cycle after a read grant → no rd_valid ever appears for that read; mem_we_b = 1 after reset.
